// File: rtl/vga_fade_output_stage.sv
`default_nettype none
// ============================================================================
// Module   : vga_fade_output_stage
// Purpose  : VGA output register stage with frame-synchronous brightness fade.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fade_output_stage #(
    parameter int PIPE            = 2,
    parameter int FRAMES_PER_STEP = 15,
    parameter bit VSYNC_POL       = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on_in,
    input  logic [5:0] rgb_in,
    input  logic       sleep,
    output logic [7:0] uo_out,
    output logic [2:0] fade_level,
    output logic       frame_tick,
    output logic       busy
);

    localparam logic [1:0] c_ST_FULL     = 2'd0;
    localparam logic [1:0] c_ST_FADE_OUT = 2'd1;
    localparam logic [1:0] c_ST_DARK     = 2'd2;
    localparam logic [1:0] c_ST_FADE_IN  = 2'd3;
    localparam logic [7:0] c_STEP_LAST   = 8'(FRAMES_PER_STEP - 1);
    localparam logic       c_SYNC_IDLE   = !VSYNC_POL;

    function automatic logic [1:0] f_scale(input logic [1:0] c, input logic [2:0] lvl);
        return 2'((5'(c) * 5'(lvl)) >> 2);
    endfunction

    logic       w_vs_active;
    logic       w_frame_start;
    logic       r_vs_active_d;
    logic       r_frame_tick;
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_level;
    logic [2:0] w_level_nxt;
    logic [7:0] r_step_cnt;
    logic [7:0] w_step_cnt_nxt;
    logic       w_busy;

    logic [PIPE-1:0] r_hs_dly;
    logic [PIPE-1:0] r_vs_dly;
    logic [5:0]      w_rgb_d;
    logic            w_de_d;
    logic [5:0]      w_col_scaled;
    logic [5:0]      r_col;

    // Previous-active resets high so a vsync level held across reset is not an edge.
    assign w_vs_active   = (vsync_in == VSYNC_POL);
    assign w_frame_start = w_vs_active & ~r_vs_active_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_active_d <= 1'b1;
            r_frame_tick  <= 1'b0;
        end else begin
            r_vs_active_d <= w_vs_active;
            r_frame_tick  <= w_frame_start;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_FULL;
            r_level    <= 3'd4;
            r_step_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_step_cnt <= w_step_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_level_nxt    = r_level;
        w_step_cnt_nxt = r_step_cnt;
        case (r_state)
            c_ST_FULL: begin
                if (sleep) begin
                    w_state_nxt    = c_ST_FADE_OUT;
                    w_step_cnt_nxt = 8'd0;
                end
            end
            c_ST_FADE_OUT: begin
                // A reversal at an already saturated level lands directly in the end state.
                if (!sleep) begin
                    w_state_nxt    = (r_level == 3'd4) ? c_ST_FULL : c_ST_FADE_IN;
                    w_step_cnt_nxt = 8'd0;
                end else if (w_frame_start) begin
                    if (r_step_cnt == c_STEP_LAST) begin
                        w_level_nxt    = r_level - 3'd1;
                        w_step_cnt_nxt = 8'd0;
                        if (r_level == 3'd1) w_state_nxt = c_ST_DARK;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + 8'd1;
                    end
                end
            end
            c_ST_DARK: begin
                if (!sleep) begin
                    w_state_nxt    = c_ST_FADE_IN;
                    w_step_cnt_nxt = 8'd0;
                end
            end
            c_ST_FADE_IN: begin
                if (sleep) begin
                    w_state_nxt    = (r_level == 3'd0) ? c_ST_DARK : c_ST_FADE_OUT;
                    w_step_cnt_nxt = 8'd0;
                end else if (w_frame_start) begin
                    if (r_step_cnt == c_STEP_LAST) begin
                        w_level_nxt    = r_level + 3'd1;
                        w_step_cnt_nxt = 8'd0;
                        if (r_level == 3'd3) w_state_nxt = c_ST_FULL;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = c_ST_FULL;
        endcase
    end

    always_comb begin
        w_busy = (r_state == c_ST_FADE_OUT) || (r_state == c_ST_FADE_IN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hs_dly <= {PIPE{c_SYNC_IDLE}};
            r_vs_dly <= {PIPE{c_SYNC_IDLE}};
        end else begin
            r_hs_dly[0] <= hsync_in;
            r_vs_dly[0] <= vsync_in;
            for (int i = 1; i < PIPE; i++) begin
                r_hs_dly[i] <= r_hs_dly[i-1];
                r_vs_dly[i] <= r_vs_dly[i-1];
            end
        end
    end

    // Colour runs one stage short so the scaling register lines up with the syncs.
    generate
        if (PIPE > 1) begin : g_rgb_dly
            logic [5:0] r_rgb_dly [PIPE-1];
            logic       r_de_dly  [PIPE-1];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE - 1; i++) begin
                        r_rgb_dly[i] <= 6'd0;
                        r_de_dly[i]  <= 1'b0;
                    end
                end else begin
                    r_rgb_dly[0] <= rgb_in;
                    r_de_dly[0]  <= display_on_in;
                    for (int i = 1; i < PIPE - 1; i++) begin
                        r_rgb_dly[i] <= r_rgb_dly[i-1];
                        r_de_dly[i]  <= r_de_dly[i-1];
                    end
                end
            end
            assign w_rgb_d = r_rgb_dly[PIPE-2];
            assign w_de_d  = r_de_dly[PIPE-2];
        end else begin : g_rgb_direct
            assign w_rgb_d = rgb_in;
            assign w_de_d  = display_on_in;
        end
    endgenerate

    always_comb begin
        w_col_scaled = {f_scale(w_rgb_d[5:4], r_level),
                        f_scale(w_rgb_d[3:2], r_level),
                        f_scale(w_rgb_d[1:0], r_level)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_col <= 6'd0;
        else        r_col <= w_de_d ? w_col_scaled : 6'd0;
    end

    assign uo_out     = {r_hs_dly[PIPE-1], r_col[0], r_col[2], r_col[4],
                         r_vs_dly[PIPE-1], r_col[1], r_col[3], r_col[5]};
    assign fade_level = r_level;
    assign frame_tick = r_frame_tick;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_vga_fade_output_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fade_output_stage
// Purpose  : Randomized scoreboard bench for vga_fade_output_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fade_output_stage;

    localparam int PIPE            = 2;
    localparam int FRAMES_PER_STEP = 2;
    localparam bit VSYNC_POL       = 1'b0;
    localparam int NCYC            = 4000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync_in;
    logic       vsync_in;
    logic       display_on_in;
    logic [5:0] rgb_in;
    logic       sleep;
    logic [7:0] uo_out;
    logic [2:0] fade_level;
    logic       frame_tick;
    logic       busy;

    vga_fade_output_stage #(
        .PIPE            (PIPE),
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .VSYNC_POL       (VSYNC_POL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .display_on_in (display_on_in),
        .rgb_in        (rgb_in),
        .sleep         (sleep),
        .uo_out        (uo_out),
        .fade_level    (fade_level),
        .frame_tick    (frame_tick),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] uo;
        logic [2:0] lvl;
        logic       tick;
        logic       bsy;
    } exp_t;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] rgb;
    } px_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: inputs seen at the output PIPE cycles later, brightness as an integer level.
    px_t  hist [PIPE];
    int   m_level    = 4;
    int   m_cnt      = 0;
    bit   m_dark     = 1'b0;
    bit   m_prev_act = 1'b1;

    task automatic model_cycle(input int cyc, input logic rst, input px_t cur, input logic slp);
        px_t  idle;
        px_t  src;
        exp_t e;
        int   r, g, b;
        bit   act, fs;
        idle.hs = !VSYNC_POL; idle.vs = !VSYNC_POL; idle.de = 1'b0; idle.rgb = 6'd0;
        for (int i = PIPE - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = cur;
        if (rst) for (int i = 0; i < PIPE; i++) hist[i] = idle;
        src = hist[PIPE-1];
        r = (int'(src.rgb[5:4]) * m_level) / 4;
        g = (int'(src.rgb[3:2]) * m_level) / 4;
        b = (int'(src.rgb[1:0]) * m_level) / 4;
        if (!src.de) begin r = 0; g = 0; b = 0; end
        e.cyc = cyc;
        e.uo  = {src.hs, 1'(b), 1'(g), 1'(r), src.vs, 1'(b >> 1), 1'(g >> 1), 1'(r >> 1)};
        if (rst) begin
            m_level = 4; m_cnt = 0; m_dark = 1'b0; m_prev_act = 1'b1;
            e.tick = 1'b0;
        end else begin
            act = (cur.vs == VSYNC_POL);
            fs  = act && !m_prev_act;
            m_prev_act = act;
            e.tick = fs;
            if (slp != m_dark) begin
                m_dark = slp;
                m_cnt  = 0;
            end else if (fs && m_level != (m_dark ? 0 : 4)) begin
                m_cnt++;
                if (m_cnt == FRAMES_PER_STEP) begin
                    m_level = m_dark ? m_level - 1 : m_level + 1;
                    m_cnt   = 0;
                end
            end
        end
        e.lvl = 3'(m_level);
        e.bsy = (m_level != (m_dark ? 0 : 4));
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (uo_out !== e.uo) begin
                    errors++;
                    $display("FAIL uo_out cyc %0d: got %b expected %b", e.cyc, uo_out, e.uo);
                end
                checks++;
                if (fade_level !== e.lvl) begin
                    errors++;
                    $display("FAIL fade_level cyc %0d: got %0d expected %0d", e.cyc, fade_level, e.lvl);
                end
                checks++;
                if (frame_tick !== e.tick) begin
                    errors++;
                    $display("FAIL frame_tick cyc %0d: got %b expected %b", e.cyc, frame_tick, e.tick);
                end
                checks++;
                if (busy !== e.bsy) begin
                    errors++;
                    $display("FAIL busy cyc %0d: got %b expected %b", e.cyc, busy, e.bsy);
                end
            end
        end
    end

    initial begin : driver
        int   fpos = 0, flen = 8, fw = 2, hold = 30;
        bit   did_mid = 1'b0;
        logic rst;
        px_t  cur;
        for (int i = 0; i < PIPE; i++) begin
            hist[i].hs = 1'b0; hist[i].vs = 1'b0; hist[i].de = 1'b0; hist[i].rgb = 6'd0;
        end
        rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; display_on_in = 1'b0;
        rgb_in = 6'd0; sleep = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            rst = (k < 3) || ($urandom_range(0, 699) == 0);
            if (!did_mid && k > 50 && m_dark && m_level == 1) begin
                rst     = 1'b1;
                did_mid = 1'b1;
            end
            if (hold == 0) begin
                sleep = ~sleep;
                hold  = $urandom_range(20, 250);
            end else begin
                hold--;
            end
            vsync_in = (fpos < fw) ? VSYNC_POL : !VSYNC_POL;
            fpos++;
            if (fpos == flen) begin
                fpos = 0;
                flen = $urandom_range(6, 10);
                fw   = $urandom_range(1, 3);
            end
            hsync_in      = 1'($urandom_range(0, 1));
            display_on_in = ($urandom_range(0, 3) != 0);
            rgb_in        = 6'($urandom_range(0, 63));
            rst_n         = !rst;
            cur.hs = hsync_in; cur.vs = vsync_in; cur.de = display_on_in; cur.rgb = rgb_in;
            model_cycle(k, rst, cur, sleep);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (!did_mid) begin
            errors++;
            $display("FAIL mid_fade_reset: got not reached expected reached");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
